shift_serializer: RTL and testbench

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

---
 rtl/shift_serializer_pkg.sv | 16 +
 rtl/shift_serializer.sv | 99 +++++++++
 tb/tb_shift_serializer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_serializer_pkg.sv
// Shared types and constants for the block-to-beat shift serializer.
// Imported by the serializer RTL and its bench.
package shift_serializer_pkg;

    localparam int DATA_W = 32;
    localparam int WORDS  = 8;
    localparam int CNT_W  = $clog2(WORDS);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    typedef logic [DATA_W*WORDS-1:0] block_t;

endpackage

// File: rtl/shift_serializer.sv
// Serializes one wide block into WORDS beats, word 0 first, with a
// one-block holding slot so consecutive blocks stream without a bubble.
module shift_serializer #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 8
) (
    input  logic                     clk_data,
    input  logic                     rst_n,
    input  logic [DATA_W*WORDS-1:0]  data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     last_o
);

    import shift_serializer_pkg::*;

    localparam int BLK_W = DATA_W * WORDS;
    localparam int CW    = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   sreg_q, sreg_d;
    logic [BLK_W-1:0]   pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic accept;
    logic xfer;
    logic last_xfer;

    assign data_o      = sreg_q[BLK_W-1 -: DATA_W];
    assign out_valid_o = (state_q == SEND);
    assign last_o      = out_valid_o && (cnt_q == LAST);
    assign in_ready_o  = rst_n && !pend_valid_q;

    assign accept    = in_valid_i && in_ready_o;
    assign xfer      = out_valid_o && out_ready_i;
    assign last_xfer = xfer && (cnt_q == LAST);

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = data_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer && !last_xfer) begin
                    sreg_d = sreg_q << DATA_W;
                    cnt_d  = cnt_q + 1'b1;
                end else if (last_xfer) begin
                    if (pend_valid_q) begin
                        sreg_d       = pend_q;
                        cnt_d        = '0;
                        pend_valid_d = 1'b0;
                    end else if (accept) begin
                        sreg_d = data_i;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                // A block arriving mid-stream parks in the holding slot
                if (accept && !last_xfer) begin
                    pend_d       = data_i;
                    pend_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_data) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: directed scenarios plus random traffic
// against a queue-based beat/block scoreboard and a collecting buffer.
module tb_shift_serializer;

    import shift_serializer_pkg::*;

    localparam int BLK_W = DATA_W * WORDS;

    logic               clk_data = 1'b0;
    logic               rst_n = 1'b0;
    block_t             data_i = '0;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic [DATA_W-1:0]  data_o;
    logic               out_valid_o;
    logic               out_ready_i = 1'b0;
    logic               last_o;

    always #5 clk_data = ~clk_data;

    shift_serializer #(
        .DATA_W(DATA_W),
        .WORDS (WORDS)
    ) u_dut (
        .clk_data   (clk_data),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .data_o     (data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .last_o     (last_o)
    );

    typedef struct packed {
        logic [DATA_W-1:0] w;
        logic              l;
    } beat_t;

    beat_t  bq[$];
    block_t blkq[$];
    block_t col = '0;
    int     outstanding = 0;
    int     xfer_cnt = 0;
    bit     rst_seen = 1'b1;
    bit     acc_last = 1'b0;
    int     n_tests = 0;
    int     n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic block_t mk_block(input logic [DATA_W-1:0] base);
        block_t b;
        b = '0;
        for (int i = 0; i < WORDS; i++)
            b[(WORDS-1-i)*DATA_W +: DATA_W] = base + DATA_W'(i);
        return b;
    endfunction

    function automatic block_t rnd_block();
        block_t b;
        for (int i = 0; i < WORDS; i++)
            b[i*DATA_W +: DATA_W] = $urandom;
        return b;
    endfunction

    // One clock: check outputs, drive inputs, advance the reference model.
    task automatic step(input logic r, input logic iv, input block_t d,
                        input logic ordy);
        logic [DATA_W-1:0] dobs;
        logic              lobs;
        bit                acc;
        bit                xf;
        beat_t             b;
        @(negedge clk_data);
        chk("in_ready", 256'(in_ready_o), 256'(rst_n && outstanding < 2));
        chk("out_valid", 256'(out_valid_o), 256'(outstanding > 0));
        if (outstanding > 0) begin
            chk("data", 256'(data_o), 256'(bq[0].w));
            chk("last", 256'(last_o), 256'(bq[0].l));
        end else begin
            chk("last_idle", 256'(last_o), 256'(0));
            if (rst_seen) chk("data_rst", 256'(data_o), 256'(0));
        end
        dobs = data_o;
        lobs = last_o;
        rst_n       = r;
        in_valid_i  = iv;
        data_i      = d;
        out_ready_i = ordy;
        #1;
        if (!r) begin
            bq.delete();
            blkq.delete();
            outstanding = 0;
            xfer_cnt = 0;
            rst_seen = 1'b1;
            acc_last = 1'b0;
            col = '0;
            return;
        end
        acc = iv && (outstanding < 2);
        xf  = ordy && (outstanding > 0);
        if (xf) begin
            b = bq.pop_front();
            col = {col[BLK_W-DATA_W-1:0], dobs};
            if (lobs) begin
                if (blkq.size() > 0) chk("roundtrip", col, blkq.pop_front());
                else chk("roundtrip_extra", 256'(blkq.size()), 256'(1));
                col = '0;
            end
            if (b.l) begin
                outstanding--;
                xfer_cnt = 0;
            end else begin
                xfer_cnt++;
            end
        end
        if (acc) begin
            for (int i = 0; i < WORDS; i++)
                bq.push_back({d[(WORDS-1-i)*DATA_W +: DATA_W], i == WORDS-1});
            blkq.push_back(d);
            outstanding++;
            rst_seen = 1'b0;
        end
        acc_last = acc;
    endtask

    task automatic send_block(input block_t b, input logic ordy);
        int k;
        k = 0;
        do begin
            step(1'b1, 1'b1, b, ordy);
            k++;
        end while (!acc_last && k < 60);
        if (!acc_last) chk("accept_timeout", 256'(acc_last), 256'(1));
    endtask

    task automatic run_until_xfer(input int n);
        int k;
        k = 0;
        while (xfer_cnt < n && k < 40) begin
            step(1'b1, 1'b0, '0, 1'b1);
            k++;
        end
        if (xfer_cnt < n) chk("beat_timeout", 256'(xfer_cnt), 256'(n));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b1);
    endtask

    initial begin
        block_t cur;
        bit     cur_v;
        logic   r;

        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        drain(2);

        // single block
        send_block(mk_block(32'hA000_0000), 1'b1);
        drain(12);

        // back-to-back blocks
        send_block(mk_block(32'hA000_0000), 1'b1);
        send_block(mk_block(32'hB000_0000), 1'b1);
        drain(20);

        // back-pressure at beat 4
        send_block(mk_block(32'hA000_0000), 1'b1);
        run_until_xfer(4);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
        drain(12);

        // third block offered while the holding slot is full
        send_block(mk_block(32'hA000_0000), 1'b1);
        send_block(mk_block(32'hB000_0000), 1'b1);
        send_block(mk_block(32'hC000_0000), 1'b1);
        drain(28);

        // reset mid-block with the holding slot full
        send_block(mk_block(32'hA000_0000), 1'b1);
        send_block(mk_block(32'hB000_0000), 1'b1);
        run_until_xfer(3);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        drain(4);
        send_block(mk_block(32'hD000_0000), 1'b1);
        drain(12);

        // random traffic
        cur   = rnd_block();
        cur_v = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!cur_v) cur_v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 199) != 0);
            step(r, cur_v, cur, $urandom_range(0, 3) != 0);
            if (acc_last || !r) begin
                cur   = rnd_block();
                cur_v = 1'b0;
            end
        end
        drain(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
